sram_dp: RTL and testbench
==========================

Name: sram_dp

Overview:
- Parameterised dual-port synchronous SRAM with two independent read/write ports sharing one storage array and one clock.
- Used as on-chip matrix/vector storage in the datapath, so one engine can write while another reads.
- Common active-low chip enable gates both ports.
- Registered read data.

Parameters:
- WIDTH, 16, data word width in bits.
- ADDR_WIDTH, 4, address width in bits.
- DEPTH, 1 << ADDR_WIDTH, number of words. Derived; do not override independently.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_ce_n  input  1  chip enable, active low, common to both ports.
- i_rdwr_n_0  input  1  port 0 mode: 1 = read, 0 = write.
- i_addr_0  input  ADDR_WIDTH  port 0 address.
- i_data_0  input  WIDTH  port 0 write data.
- o_data_0  output  WIDTH  port 0 registered read data.
- i_rdwr_n_1  input  1  port 1 mode: 1 = read, 0 = write (same polarity as port 0).
- i_addr_1  input  ADDR_WIDTH  port 1 address.
- i_data_1  input  WIDTH  port 1 write data.
- o_data_1  output  WIDTH  port 1 registered read data.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active low.
- Reset:
  - While i_rst_n = 0, o_data_0 and o_data_1 are forced to 0 immediately, independent of the clock.
  - The memory array is not reset. Contents are undefined until written, and reset does not clear data already written.
- Chip disabled (i_ce_n = 1): no writes occur and both output registers hold their values.
- Write, per port p, on a rising edge with i_ce_n = 0 and i_rdwr_n_p = 0:
  - mem[i_addr_p] <= i_data_p.
  - o_data_p holds its previous value during a write cycle.
- Read, per port p, on a rising edge with i_ce_n = 0 and i_rdwr_n_p = 1:
  - o_data_p <= mem[i_addr_p].
  - Latency is 1 cycle: data is valid after the edge that samples the address.
- Ports are fully independent; both may read, both may write, or one of each in the same cycle.
- Read-first semantics: a read of an address being written in the same cycle by the other port returns the OLD contents. The new value is visible from the next read.
- Write collision: both ports write the same address in the same cycle -> port 0 data is stored and port 1 data is discarded. This priority is deterministic.
- Both ports reading the same address: both outputs receive the same word.
- Addresses cover the full range 0..DEPTH-1; there is no out-of-range case and no wrap logic.
- Data is stored and returned unmodified at WIDTH bits; no arithmetic.
- The array must be coded as a register array, inferable as true dual-port block RAM where the target allows.

Decomposition:
- No shared package types needed. WIDTH/ADDR_WIDTH defaults may live in the project-wide parameter package if one exists.
- Single flat module; no sub-module. The two port processes are symmetric blocks in the same module.

Test Plan (WIDTH=16, ADDR_WIDTH=4):
- Reset: assert i_rst_n=0 mid-cycle after outputs are nonzero -> o_data_0 and o_data_1 are 0 immediately. Deassert, then read addr 3 (previously written 3) -> returns 3.
- Fill and read-back: write mem[i]=i via port 0 for i=0..15, then read i=0..15 via port 1 -> o_data_1 equals i exactly one cycle after each address is applied. Repeat with port 1 writing and port 0 reading.
- Chip enable: with i_ce_n=1, attempt a port 0 write of 0xBEEF to addr 5 -> a later read of addr 5 returns the old value, and o_data_0/o_data_1 do not change while disabled.
- Cross-port same-address: port 0 writes 0x1234 to addr 7 (old 7) while port 1 reads addr 7 -> o_data_1=7. Next cycle port 1 reads addr 7 -> 0x1234.
- Write collision: both ports write addr 9, port 0 0xAAAA and port 1 0x5555 -> a subsequent read of addr 9 returns 0xAAAA.
- Concurrent independent traffic: port 0 writes addr 2=0x00F0 while port 1 reads addr 4 (=4) -> o_data_1=4 and o_data_0 unchanged. Next cycle both ports read addr 2 -> both outputs are 0x00F0.

Source files
------------

// File: rtl/sram_dp.sv
// Dual-port synchronous SRAM: two independent read/write ports on one array,
// shared active-low chip enable, registered read-first outputs.
module sram_dp #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_ce_n,
  input  logic                  i_rdwr_n_0,
  input  logic [ADDR_WIDTH-1:0] i_addr_0,
  input  logic [WIDTH-1:0]      i_data_0,
  output logic [WIDTH-1:0]      o_data_0,
  input  logic                  i_rdwr_n_1,
  input  logic [ADDR_WIDTH-1:0] i_addr_1,
  input  logic [WIDTH-1:0]      i_data_1,
  output logic [WIDTH-1:0]      o_data_1
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0] data_0_d, data_0_q;
  logic [WIDTH-1:0] data_1_d, data_1_q;

  logic wr_0, wr_1, rd_0, rd_1;

  assign wr_0 = !i_ce_n && !i_rdwr_n_0;
  assign wr_1 = !i_ce_n && !i_rdwr_n_1;
  assign rd_0 = !i_ce_n &&  i_rdwr_n_0;
  assign rd_1 = !i_ce_n &&  i_rdwr_n_1;

  // Array is deliberately unreset. Port 0 is applied last so it wins a
  // same-address collision; reads see pre-edge contents (read-first).
  always_ff @(posedge i_clk) begin
    if (wr_1) mem[i_addr_1] <= i_data_1;
    if (wr_0) mem[i_addr_0] <= i_data_0;
  end

  always_comb begin
    data_0_d = data_0_q;
    if (rd_0) data_0_d = mem[i_addr_0];
  end

  always_comb begin
    data_1_d = data_1_q;
    if (rd_1) data_1_d = mem[i_addr_1];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_0_q <= '0;
      data_1_q <= '0;
    end else begin
      data_0_q <= data_0_d;
      data_1_q <= data_1_d;
    end
  end

  assign o_data_0 = data_0_q;
  assign o_data_1 = data_1_q;

endmodule

// File: tb/tb_sram_dp.sv
// Bench for sram_dp: directed scenarios plus random traffic, checked against
// a word-array model of the dual-port read-first memory.
module tb_sram_dp;
  localparam int W  = 16;
  localparam int AW = 4;
  localparam int D  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ce_n;
  logic          rw0, rw1;
  logic [AW-1:0] a0, a1;
  logic [W-1:0]  d0, d1;
  logic [W-1:0]  q0, q1;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] m_mem [D];
  logic [W-1:0] m_o0, m_o1;

  sram_dp #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce_n(ce_n),
    .i_rdwr_n_0(rw0), .i_addr_0(a0), .i_data_0(d0), .o_data_0(q0),
    .i_rdwr_n_1(rw1), .i_addr_1(a1), .i_data_1(d1), .o_data_1(q1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, advance model, compare both outputs after the edge.
  task automatic cyc(input string tag, input logic ce, input logic r0, input int ad0,
                     input logic [W-1:0] wd0, input logic r1, input int ad1,
                     input logic [W-1:0] wd1);
    @(negedge clk);
    ce_n = ce; rw0 = r0; a0 = AW'(ad0); d0 = wd0;
    rw1 = r1; a1 = AW'(ad1); d1 = wd1;
    @(posedge clk);
    if (!ce) begin
      if (r0) m_o0 = m_mem[AW'(ad0)];
      if (r1) m_o1 = m_mem[AW'(ad1)];
      if (!r1) m_mem[AW'(ad1)] = wd1;
      if (!r0) m_mem[AW'(ad0)] = wd0;
    end
    #1;
    chk({tag, "/o0"}, q0, m_o0);
    chk({tag, "/o1"}, q1, m_o1);
  endtask

  initial begin
    logic [W-1:0] h0, h1;
    rst_n = 1'b0; ce_n = 1'b1; rw0 = 1'b1; rw1 = 1'b1;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    m_o0 = '0; m_o1 = '0;
    #12;
    chk("rst_o0", q0, 16'h0);
    chk("rst_o1", q1, 16'h0);
    @(negedge clk); rst_n = 1'b1;

    // Fill via port 0; port 1 seeds addr 15 first, then reads back behind it.
    cyc("fill0", 1'b0, 1'b0, 0, 16'd0, 1'b0, 15, 16'd15);
    for (int i = 1; i < D; i++)
      cyc("fill0", 1'b0, 1'b0, i, W'(i), 1'b1, i - 1, 16'h0);
    for (int i = 0; i < D; i++) begin
      cyc("rd1", 1'b0, 1'b1, D - 1 - i, 16'h0, 1'b1, i, 16'h0);
      chk("rd1_const", q1, W'(i));
    end

    // Chip disabled: write attempt must be ignored and outputs held.
    cyc("ce_pre", 1'b0, 1'b1, 5, 16'h0, 1'b1, 6, 16'h0);
    h0 = q0; h1 = q1;
    cyc("ce_off", 1'b1, 1'b0, 5, 16'hBEEF, 1'b0, 6, 16'hCAFE);
    chk("ce_hold0", q0, h0);
    chk("ce_hold1", q1, h1);
    cyc("ce_rd", 1'b0, 1'b1, 5, 16'h0, 1'b1, 6, 16'h0);
    chk("ce_rd5", q0, 16'd5);
    chk("ce_rd6", q1, 16'd6);

    // Read-first across ports.
    cyc("xport", 1'b0, 1'b0, 7, 16'h1234, 1'b1, 7, 16'h0);
    chk("xport_old", q1, 16'd7);
    chk("xport_hold0", q0, 16'd5);
    cyc("xport2", 1'b0, 1'b1, 0, 16'h0, 1'b1, 7, 16'h0);
    chk("xport_new", q1, 16'h1234);

    // Write collision: port 0 wins.
    cyc("coll", 1'b0, 1'b0, 9, 16'hAAAA, 1'b0, 9, 16'h5555);
    cyc("coll_rd", 1'b0, 1'b1, 9, 16'h0, 1'b1, 9, 16'h0);
    chk("coll_rd0", q0, 16'hAAAA);
    chk("coll_rd1", q1, 16'hAAAA);

    // Concurrent independent traffic.
    cyc("conc", 1'b0, 1'b0, 2, 16'h00F0, 1'b1, 4, 16'h0);
    chk("conc_rd4", q1, 16'd4);
    chk("conc_hold0", q0, 16'hAAAA);
    cyc("conc2", 1'b0, 1'b1, 2, 16'h0, 1'b1, 2, 16'h0);
    chk("conc_both0", q0, 16'h00F0);
    chk("conc_both1", q1, 16'h00F0);

    // Fill via port 1, read back via port 0.
    for (int i = 0; i < D; i++)
      cyc("fill1", 1'b0, 1'b1, 0, 16'h0, 1'b0, i, W'(i * 16'h0101));
    for (int i = 0; i < D; i++) begin
      cyc("rd0", 1'b0, 1'b1, i, 16'h0, 1'b1, D - 1 - i, 16'h0);
      chk("rd0_const", q0, W'(i * 16'h0101));
    end

    // Random traffic.
    for (int n = 0; n < 300; n++)
      cyc("rand", ($urandom_range(0, 7) == 0), 1'($urandom), int'($urandom_range(0, D - 1)),
          W'($urandom), 1'($urandom), int'($urandom_range(0, D - 1)), W'($urandom));

    // Reset mid-cycle with nonzero outputs; array contents survive.
    cyc("rst_w3", 1'b0, 1'b0, 3, 16'd3, 1'b0, 8, 16'h8888);
    cyc("rst_pre", 1'b0, 1'b1, 8, 16'h0, 1'b1, 8, 16'h0);
    chk("rst_pre_nz", q0, 16'h8888);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async0", q0, 16'h0);
    chk("rst_async1", q1, 16'h0);
    m_o0 = '0; m_o1 = '0;
    @(negedge clk); rst_n = 1'b1;
    cyc("rst_rd3", 1'b0, 1'b1, 3, 16'h0, 1'b1, 3, 16'h0);
    chk("rst_keep3", q0, 16'd3);
    chk("rst_keep3b", q1, 16'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
